// File: rtl/lsu_addr_gen_pkg.sv
// Shared types and helpers for the LSU address generator.
// Access-size and FSM-state encodings plus lane-mask helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } access_size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2
  } lsu_state_e;

  // Base lane mask of an access, before shifting by the lane offset.
  function automatic logic [7:0] size_mask(access_size_e sz);
    logic [7:0] m;
    case (sz)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      SZ_D:    m = 8'hFF;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  // True when the lane offset is not a multiple of the access size.
  function automatic logic off_misaligned(access_size_e sz, logic [2:0] off);
    logic [2:0] low;
    case (sz)
      SZ_B:    low = 3'd0;
      SZ_H:    low = 3'd1;
      SZ_W:    low = 3'd3;
      SZ_D:    low = 3'd7;
      default: low = 3'd0;
    endcase
    return |(off & low);
  endfunction

endpackage

// File: rtl/lsu_addr_gen_if.sv
// Data-memory request port of the LSU address generator.
// master = address generator, slave = memory.
interface lsu_addr_gen_if #(
  parameter int DATA_WIDTH = 32
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);

  logic                  mem_valid;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [BYTES-1:0]      mem_byte_en;
  logic                  mem_we;
  logic                  mem_sign;
  logic [1:0]            mem_size;
  logic [OFF_W-1:0]      mem_off;
  logic                  mem_last;

  modport master (
    output mem_valid, mem_addr, mem_byte_en, mem_we, mem_sign,
           mem_size, mem_off, mem_last,
    input  mem_ready
  );

  modport slave (
    input  mem_valid, mem_addr, mem_byte_en, mem_we, mem_sign,
           mem_size, mem_off, mem_last,
    output mem_ready
  );
endinterface

// File: rtl/lsu_addr_gen_fwd_mux.sv
// Priority forwarding mux for an operand: the youngest matching source
// (lowest index) wins; x0 is never forwarded. Purely combinational.
module lsu_fwd_mux #(
  parameter int DATA_WIDTH     = 32,
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int NUM_FWD        = 3
) (
  input  logic [GPR_ADDR_WIDTH-1:0]         rs_idx,
  input  logic [DATA_WIDTH-1:0]             rs_data,
  input  logic [NUM_FWD-1:0]                fwd_vld,
  input  logic [NUM_FWD*GPR_ADDR_WIDTH-1:0] fwd_rd,
  input  logic [NUM_FWD*DATA_WIDTH-1:0]     fwd_data,
  output logic [DATA_WIDTH-1:0]             oper
);

  // Scan oldest to youngest so the lowest matching index overrides the rest.
  always_comb begin
    oper = rs_data;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_vld[k] && (fwd_rd[k*GPR_ADDR_WIDTH +: GPR_ADDR_WIDTH] == rs_idx) &&
          (rs_idx != {GPR_ADDR_WIDTH{1'b0}})) begin
        oper = fwd_data[k*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        oper = oper;
      end
    end
  end

endmodule

// File: rtl/lsu_addr_gen.sv
// EX-stage load/store address generator: forwards rs1, computes rs1+imm,
// lane enables and sign control, and issues one registered beat per cycle.
// Build option LSU_MISALIGN_SPLIT_EN: split misaligned accesses into two
// beats; when undefined, misaligned accesses are rejected via misalign_err.
module lsu_addr_gen
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int NUM_FWD        = 3
) (
  input  logic                              addr_clk,
  input  logic                              addr_rst,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_load,
  input  logic                              req_store,
  input  logic [1:0]                        req_size,
  input  logic                              req_unsigned,
  input  logic [GPR_ADDR_WIDTH-1:0]         rs1_idx,
  input  logic [DATA_WIDTH-1:0]             rs1_data,
  input  logic [DATA_WIDTH-1:0]             imm_val,
  input  logic [NUM_FWD-1:0]                fwd_vld,
  input  logic [NUM_FWD*GPR_ADDR_WIDTH-1:0] fwd_rd,
  input  logic [NUM_FWD*DATA_WIDTH-1:0]     fwd_data,
  lsu_addr_gen_if.master                    mem,
  output logic                              misalign_err
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam access_size_e MAX_SZ = (DATA_WIDTH == 64) ? SZ_D : SZ_W;
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam logic SPLIT_EN = 1'b1;
`else
  localparam logic SPLIT_EN = 1'b0;
`endif

  logic [DATA_WIDTH-1:0]  oper_s, ea_s;
  logic [OFF_W-1:0]       off_s;
  access_size_e           size_s;
  logic [2*BYTES-1:0]     wide_be_s;
  logic                   legal_s, misalign_s, split_s, sign_s;
  logic                   accept_s, launch_s, reject_s;
  lsu_state_e             state_r, state_nxt_s;

  logic                   mem_valid_r, mem_we_r, mem_sign_r, mem_last_r, err_r;
  logic [DATA_WIDTH-1:0]  mem_addr_r;
  logic [BYTES-1:0]       mem_be_r, hi_be_r;
  logic [1:0]             mem_size_r;
  logic [OFF_W-1:0]       mem_off_r;

  lsu_fwd_mux #(
    .DATA_WIDTH    (DATA_WIDTH),
    .GPR_ADDR_WIDTH(GPR_ADDR_WIDTH),
    .NUM_FWD       (NUM_FWD)
  ) u_fwd_mux (
    .rs_idx  (rs1_idx),
    .rs_data (rs1_data),
    .fwd_vld (fwd_vld),
    .fwd_rd  (fwd_rd),
    .fwd_data(fwd_data),
    .oper    (oper_s)
  );

  assign size_s     = access_size_e'(req_size);
  assign ea_s       = oper_s + imm_val;
  assign off_s      = ea_s[OFF_W-1:0];
  // Low half is the first-beat (or only-beat) mask, high half the spill-over.
  assign wide_be_s  = (2*BYTES)'(size_mask(size_s)) << off_s;
  assign legal_s    = (DATA_WIDTH == 64) || (size_s != SZ_D);
  assign misalign_s = !legal_s || off_misaligned(size_s, 3'(off_s));
  assign split_s    = SPLIT_EN && legal_s && misalign_s;
  assign sign_s     = req_load && !req_unsigned && (size_s != MAX_SZ);
  assign accept_s   = req_valid && req_ready && (req_load ^ req_store);
  assign launch_s   = accept_s && (!misalign_s || split_s);
  assign reject_s   = accept_s && misalign_s && !split_s;

  // FSM state register.
  always_ff @(posedge addr_clk or negedge addr_rst) begin
    if (!addr_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: a consumed final beat may immediately launch the next access.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (launch_s) state_nxt_s = ST_BEAT0;
        else          state_nxt_s = ST_IDLE;
      end
      ST_BEAT0: begin
        if (!mem.mem_ready)   state_nxt_s = ST_BEAT0;
        else if (!mem_last_r) state_nxt_s = ST_BEAT1;
        else if (launch_s)    state_nxt_s = ST_BEAT0;
        else                  state_nxt_s = ST_IDLE;
      end
      ST_BEAT1: begin
        if (!mem.mem_ready) state_nxt_s = ST_BEAT1;
        else if (launch_s)  state_nxt_s = ST_BEAT0;
        else                state_nxt_s = ST_IDLE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: accept a new request only when the final beat is leaving.
  always_comb begin
    req_ready = 1'b0;
    case (state_r)
      ST_IDLE:  req_ready = 1'b1;
      ST_BEAT0: req_ready = mem.mem_ready && mem_last_r;
      ST_BEAT1: req_ready = mem.mem_ready && mem_last_r;
      default:  req_ready = 1'b0;
    endcase
  end

  // Beat registers: load on launch, advance to the second beat, clear when drained, hold on stall.
  always_ff @(posedge addr_clk or negedge addr_rst) begin
    if (!addr_rst) begin
      mem_valid_r <= 1'b0;
      mem_addr_r  <= {DATA_WIDTH{1'b0}};
      mem_be_r    <= {BYTES{1'b0}};
      hi_be_r     <= {BYTES{1'b0}};
      mem_we_r    <= 1'b0;
      mem_sign_r  <= 1'b0;
      mem_size_r  <= 2'd0;
      mem_off_r   <= {OFF_W{1'b0}};
      mem_last_r  <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      err_r <= reject_s;
      if (launch_s) begin
        mem_valid_r <= 1'b1;
        mem_addr_r  <= split_s ? {ea_s[DATA_WIDTH-1:OFF_W], {OFF_W{1'b0}}} : ea_s;
        mem_be_r    <= wide_be_s[BYTES-1:0];
        hi_be_r     <= wide_be_s[2*BYTES-1:BYTES];
        mem_we_r    <= req_store;
        mem_sign_r  <= sign_s;
        mem_size_r  <= req_size;
        mem_off_r   <= off_s;
        mem_last_r  <= !split_s;
      end else if (mem_valid_r && mem.mem_ready && !mem_last_r) begin
        mem_addr_r  <= mem_addr_r + DATA_WIDTH'(BYTES);
        mem_be_r    <= hi_be_r;
        mem_last_r  <= 1'b1;
      end else if (mem_valid_r && mem.mem_ready) begin
        mem_valid_r <= 1'b0;
        mem_addr_r  <= {DATA_WIDTH{1'b0}};
        mem_be_r    <= {BYTES{1'b0}};
        hi_be_r     <= {BYTES{1'b0}};
        mem_we_r    <= 1'b0;
        mem_sign_r  <= 1'b0;
        mem_size_r  <= 2'd0;
        mem_off_r   <= {OFF_W{1'b0}};
        mem_last_r  <= 1'b0;
      end else begin
        mem_valid_r <= mem_valid_r;
      end
    end
  end

  assign mem.mem_valid   = mem_valid_r;
  assign mem.mem_addr    = mem_addr_r;
  assign mem.mem_byte_en = mem_be_r;
  assign mem.mem_we      = mem_we_r;
  assign mem.mem_sign    = mem_sign_r;
  assign mem.mem_size    = mem_size_r;
  assign mem.mem_off     = mem_off_r;
  assign mem.mem_last    = mem_last_r;
  assign misalign_err    = err_r;

endmodule

// File: tb/tb_lsu_addr_gen.sv
// Directed bench for lsu_addr_gen (DATA_WIDTH=32): vector table plus
// hand-written stall, misalignment and reset sequences.
module tb_lsu_addr_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_load = 1'b0, req_store = 1'b0, req_unsigned = 1'b0;
  logic        req_ready;
  logic [1:0]  req_size = 2'd0;
  logic [4:0]  rs1_idx = 5'd0;
  logic [31:0] rs1_data = 32'd0, imm_val = 32'd0;
  logic [2:0]  fwd_vld = 3'd0;
  logic [14:0] fwd_rd = 15'd0;
  logic [95:0] fwd_data = 96'd0;
  logic        misalign_err;

  int n_chk = 0;
  int n_fail = 0;

  lsu_addr_gen_if #(.DATA_WIDTH(32)) mif ();

  lsu_addr_gen #(.DATA_WIDTH(32), .GPR_ADDR_WIDTH(5), .NUM_FWD(3)) dut (
    .addr_clk(clk), .addr_rst(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_load(req_load), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .rs1_idx(rs1_idx), .rs1_data(rs1_data), .imm_val(imm_val),
    .fwd_vld(fwd_vld), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .mem(mif), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] rs1;
    logic [31:0] imm;
    logic [1:0]  size;
    logic        ld, st, uns;
    logic [2:0]  fvld;
    logic [14:0] frd;
    logic [95:0] fdata;
    int          kind;   // 0 = one beat, 1 = rejected, 2 = ignored
    logic [31:0] eaddr;
    logic [3:0]  ebe;
    logic        ewe, esign;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rs1_idx = v.idx; rs1_data = v.rs1; imm_val = v.imm; req_size = v.size;
    req_load = v.ld; req_store = v.st; req_unsigned = v.uns;
    fwd_vld = v.fvld; fwd_rd = v.frd; fwd_data = v.fdata;
    req_valid = 1'b1;
  endtask

  task automatic drive_lw(input logic [31:0] base);
    rs1_idx = 5'd1; rs1_data = base; imm_val = 32'd0; req_size = 2'd2;
    req_load = 1'b1; req_store = 1'b0; req_unsigned = 1'b0;
    fwd_vld = 3'd0; req_valid = 1'b1;
  endtask

  initial begin
    //         idx    rs1            imm            sz    ld    st    uns   fvld    frd                     fdata                                  kind eaddr          be     we    sign
    vt[0]  = '{5'd1, 32'h0000_1000, 32'h0000_0008, 2'd2, 1'b1, 1'b0, 1'b0, 3'b000, 15'd0,                  96'd0,                                 0, 32'h0000_1008, 4'hF, 1'b0, 1'b0};
    vt[1]  = '{5'd5, 32'h0000_0999, 32'h0000_0004, 2'd0, 1'b0, 1'b1, 1'b0, 3'b011, {5'd7, 5'd5, 5'd5},     {32'h0, 32'h0000_0300, 32'h0000_0200}, 0, 32'h0000_0204, 4'h1, 1'b1, 1'b0};
    vt[2]  = '{5'd0, 32'h0000_0051, 32'h0000_0004, 2'd0, 1'b0, 1'b1, 1'b0, 3'b011, {5'd0, 5'd0, 5'd0},     {32'h0, 32'h0000_0300, 32'h0000_0200}, 0, 32'h0000_0055, 4'h2, 1'b1, 1'b0};
    vt[3]  = '{5'd5, 32'h0000_0999, 32'h0000_0001, 2'd0, 1'b1, 1'b0, 1'b0, 3'b010, {5'd0, 5'd5, 5'd5},     {32'h0, 32'h0000_0300, 32'h0000_0200}, 0, 32'h0000_0301, 4'h2, 1'b0, 1'b1};
    vt[4]  = '{5'd2, 32'h0000_2000, 32'h0000_0002, 2'd1, 1'b1, 1'b0, 1'b1, 3'b000, 15'd0,                  96'd0,                                 0, 32'h0000_2002, 4'hC, 1'b0, 1'b0};
    vt[5]  = '{5'd2, 32'h0000_2000, 32'h0000_0002, 2'd1, 1'b1, 1'b0, 1'b0, 3'b000, 15'd0,                  96'd0,                                 0, 32'h0000_2002, 4'hC, 1'b0, 1'b1};
    vt[6]  = '{5'd3, 32'hFFFF_FFFC, 32'h0000_0008, 2'd2, 1'b1, 1'b0, 1'b0, 3'b000, 15'd0,                  96'd0,                                 0, 32'h0000_0004, 4'hF, 1'b0, 1'b0};
    vt[7]  = '{5'd3, 32'h0000_1000, 32'hFFFF_FFFE, 2'd1, 1'b1, 1'b0, 1'b0, 3'b000, 15'd0,                  96'd0,                                 0, 32'h0000_0FFE, 4'hC, 1'b0, 1'b1};
    vt[8]  = '{5'd4, 32'h0000_3000, 32'h0000_0003, 2'd0, 1'b1, 1'b0, 1'b1, 3'b000, 15'd0,                  96'd0,                                 0, 32'h0000_3003, 4'h8, 1'b0, 1'b0};
    vt[9]  = '{5'd4, 32'h0000_3000, 32'h0000_0003, 2'd0, 1'b0, 1'b1, 1'b0, 3'b000, 15'd0,                  96'd0,                                 0, 32'h0000_3003, 4'h8, 1'b1, 1'b0};
    vt[10] = '{5'd4, 32'h0000_1000, 32'h0000_0000, 2'd3, 1'b1, 1'b0, 1'b0, 3'b000, 15'd0,                  96'd0,                                 1, 32'h0,         4'h0, 1'b0, 1'b0};
    vt[11] = '{5'd4, 32'h0000_1000, 32'h0000_0000, 2'd2, 1'b1, 1'b1, 1'b0, 3'b000, 15'd0,                  96'd0,                                 2, 32'h0,         4'h0, 1'b0, 1'b0};
    vt[12] = '{5'd4, 32'h0000_1000, 32'h0000_0000, 2'd2, 1'b0, 1'b0, 1'b0, 3'b000, 15'd0,                  96'd0,                                 2, 32'h0,         4'h0, 1'b0, 1'b0};
    vt[13] = '{5'd5, 32'h0000_0999, 32'h0000_0000, 2'd2, 1'b1, 1'b0, 1'b0, 3'b100, {5'd5, 5'd0, 5'd0},     {32'h0000_0700, 32'h0, 32'h0},         0, 32'h0000_0700, 4'hF, 1'b0, 1'b0};

    mif.mem_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(mif.mem_valid), 32'd0);
    chk("rst_addr", mif.mem_addr, 32'd0);
    chk("rst_be", 32'(mif.mem_byte_en), 32'd0);
    chk("rst_last", 32'(mif.mem_last), 32'd0);
    chk("rst_err", 32'(misalign_err), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;

    // Table-driven single-beat / reject / ignore vectors
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vt[i]);
      @(negedge clk);
      req_valid = 1'b0;
      if (vt[i].kind == 0) begin
        chk($sformatf("v%0d_valid", i), 32'(mif.mem_valid), 32'd1);
        chk($sformatf("v%0d_addr", i), mif.mem_addr, vt[i].eaddr);
        chk($sformatf("v%0d_be", i), 32'(mif.mem_byte_en), 32'(vt[i].ebe));
        chk($sformatf("v%0d_we", i), 32'(mif.mem_we), 32'(vt[i].ewe));
        chk($sformatf("v%0d_sign", i), 32'(mif.mem_sign), 32'(vt[i].esign));
        chk($sformatf("v%0d_size", i), 32'(mif.mem_size), 32'(vt[i].size));
        chk($sformatf("v%0d_off", i), 32'(mif.mem_off), 32'(vt[i].eaddr[1:0]));
        chk($sformatf("v%0d_last", i), 32'(mif.mem_last), 32'd1);
        chk($sformatf("v%0d_err", i), 32'(misalign_err), 32'd0);
      end else begin
        chk($sformatf("v%0d_valid", i), 32'(mif.mem_valid), 32'd0);
        chk($sformatf("v%0d_err", i), 32'(misalign_err), (vt[i].kind == 1) ? 32'd1 : 32'd0);
      end
      @(negedge clk);
      chk($sformatf("v%0d_drain_valid", i), 32'(mif.mem_valid), 32'd0);
      chk($sformatf("v%0d_drain_err", i), 32'(misalign_err), 32'd0);
    end

    // Misaligned word at 0x1003
    @(negedge clk);
    drive_lw(32'h0000_1003);
    @(negedge clk);
    req_valid = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
    chk("mis_b0_valid", 32'(mif.mem_valid), 32'd1);
    chk("mis_b0_addr", mif.mem_addr, 32'h0000_1000);
    chk("mis_b0_be", 32'(mif.mem_byte_en), 32'h8);
    chk("mis_b0_last", 32'(mif.mem_last), 32'd0);
    chk("mis_b0_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("mis_b1_valid", 32'(mif.mem_valid), 32'd1);
    chk("mis_b1_addr", mif.mem_addr, 32'h0000_1004);
    chk("mis_b1_be", 32'(mif.mem_byte_en), 32'h7);
    chk("mis_b1_last", 32'(mif.mem_last), 32'd1);
    chk("mis_b1_off", 32'(mif.mem_off), 32'd3);
    chk("mis_b1_size", 32'(mif.mem_size), 32'd2);
    @(negedge clk);
    chk("mis_done_valid", 32'(mif.mem_valid), 32'd0);
`else
    chk("mis_err", 32'(misalign_err), 32'd1);
    chk("mis_valid", 32'(mif.mem_valid), 32'd0);
    @(negedge clk);
    chk("mis_err_pulse", 32'(misalign_err), 32'd0);
    chk("mis_valid2", 32'(mif.mem_valid), 32'd0);
`endif

    // Stall for 3 cycles with a second request pending, then release
    @(negedge clk);
    mif.mem_ready = 1'b0;
    drive_lw(32'h0000_0100);
    @(negedge clk);
    chk("stall_valid", 32'(mif.mem_valid), 32'd1);
    chk("stall_addr0", mif.mem_addr, 32'h0000_0100);
    chk("stall_ready0", 32'(req_ready), 32'd0);
    rs1_data = 32'h0000_0200;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_valid", c), 32'(mif.mem_valid), 32'd1);
      chk($sformatf("stall%0d_addr", c), mif.mem_addr, 32'h0000_0100);
      chk($sformatf("stall%0d_be", c), 32'(mif.mem_byte_en), 32'hF);
      chk($sformatf("stall%0d_last", c), 32'(mif.mem_last), 32'd1);
      chk($sformatf("stall%0d_ready", c), 32'(req_ready), 32'd0);
    end
    mif.mem_ready = 1'b1;
    #1;
    chk("release_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("b2b_valid", 32'(mif.mem_valid), 32'd1);
    chk("b2b_addr", mif.mem_addr, 32'h0000_0200);
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_drain", 32'(mif.mem_valid), 32'd0);

    // Reset in the middle of BEAT0
    @(negedge clk);
    mif.mem_ready = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
    drive_lw(32'h0000_0403);
`else
    drive_lw(32'h0000_0400);
`endif
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_valid", 32'(mif.mem_valid), 32'd1);
    chk("mid_addr", mif.mem_addr, 32'h0000_0400);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(mif.mem_valid), 32'd0);
    chk("mrst_addr", mif.mem_addr, 32'd0);
    chk("mrst_be", 32'(mif.mem_byte_en), 32'd0);
    chk("mrst_last", 32'(mif.mem_last), 32'd0);
    chk("mrst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    mif.mem_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(mif.mem_valid), 32'd0);
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("post_rst_nobeat1", 32'(mif.mem_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_addr_gen.md
Name: lsu_addr_gen

Overview:
Parametrised load/store address generator for the EX stage of the compressed-ISA core. It covers full RISC-V sizes (byte, half, word; double when DATA_WIDTH=64), signed and unsigned loads, and N-deep rs1 forwarding. It sits between ID/EX and the data-memory port, computes rs1+imm, byte enables and sign control, and presents one registered request per beat to memory under a valid/ready handshake. It also detects misaligned accesses, which are reported or split depending on a build option.

Parameters:
DATA_WIDTH, 32, datapath and address width (32 or 64).
GPR_ADDR_WIDTH, 5, register index width.
NUM_FWD, 3, number of forwarding sources; index 0 is the youngest.
BYTES, DATA_WIDTH/8, derived localparam (byte lanes).
OFF_W, $clog2(BYTES), derived localparam (lane-offset width).

Ports:
addr_clk  in  1  clock.
addr_rst  in  1  asynchronous reset, active-low.
req_valid  in  1  request from ID/EX.
req_ready  out  1  block can accept a request this cycle.
req_load  in  1  request is a load.
req_store  in  1  request is a store.
req_size  in  2  access size: 0=B, 1=H, 2=W, 3=D.
req_unsigned  in  1  zero-extend the load (lbu/lhu/lwu).
rs1_idx  in  GPR_ADDR_WIDTH  rs1 register index.
rs1_data  in  DATA_WIDTH  rs1 value read from the register file.
imm_val  in  DATA_WIDTH  sign-extended offset.
fwd_vld  in  NUM_FWD  source k will write its rd.
fwd_rd  in  NUM_FWD*GPR_ADDR_WIDTH  flattened destination indices.
fwd_data  in  NUM_FWD*DATA_WIDTH  flattened result data.
mem_valid  out  1  memory request valid.
mem_ready  in  1  memory accepts the current beat.
mem_addr  out  DATA_WIDTH  beat address.
mem_byte_en  out  BYTES  lane enables.
mem_we  out  1  beat is a store.
mem_sign  out  1  sign-extend the load result.
mem_size  out  2  original access size.
mem_off  out  OFF_W  original address[OFF_W-1:0], used for load alignment.
mem_last  out  1  final beat of the access.
misalign_err  out  1  one-cycle pulse: access rejected.

Behaviour:
- Reset: all outputs are 0, except req_ready, which is 1. The FSM resets to IDLE.
- Accept condition: a request is accepted when req_valid && req_ready && (req_load ^ req_store). Both set, or neither set, means the request is ignored.
- Operand select: oper1 is fwd_data[k] for the lowest k with fwd_vld[k] && fwd_rd[k]==rs1_idx && rs1_idx!=0; otherwise it is rs1_data.
- Address: ea = oper1 + imm_val, modulo 2^DATA_WIDTH. off = ea[OFF_W-1:0].
- Base lane mask: B=1, H=3, W=0xF, D=0xFF.
- Alignment check: an access is misaligned when off is not a multiple of the access size.
- Illegal size: D with DATA_WIDTH=32 is treated as misaligned and is never split.
- Aligned access: mem_byte_en = mask<<off and mem_addr = ea, both registered. mem_valid asserts the cycle after accept, with mem_last=1.
- Sign control: mem_sign = req_load && !req_unsigned && size != max. mem_we = req_store.
- FSM states: IDLE -> BEAT0 -> (BEAT1) -> IDLE.
- IDLE: req_ready=1.
- BEAT0 and BEAT1: req_ready = mem_ready && mem_last, so back-to-back accesses proceed with no bubble.
- Stall hold: while mem_valid && !mem_ready, every mem_* output holds stable.
- Reset mid-beat: aborts the access. No partial state survives.

Optional Feature:
Macro: LSU_MISALIGN_SPLIT_EN.
- Defined: a misaligned access (legal size) becomes two beats.
  - BEAT0: mem_addr = ea with the low OFF_W bits cleared; mem_byte_en = (mask<<off) truncated to BYTES; mem_last=0.
  - BEAT1: mem_addr = BEAT0 address + BYTES; mem_byte_en = mask>>(BYTES-off); mem_last=1.
  - mem_off and mem_size are held across both beats.
  - Wrap at the top of the address space is modulo.
- Undefined: a misaligned access produces no beat. misalign_err pulses for one cycle, registered, and the FSM stays in IDLE.
- Illegal size: misalign_err pulses in both builds.

Decomposition:
- Package lsu_pkg holds:
  - enum access_size_e {SZ_B, SZ_H, SZ_W, SZ_D};
  - enum lsu_state_e {ST_IDLE, ST_BEAT0, ST_BEAT1};
  - function size_mask(access_size_e) returning the base lane mask.
- Sub-module lsu_fwd_mux: the parametrised NUM_FWD priority forwarding mux, purely combinational and reusable by the ALU operand path.

Test Plan:
1. Aligned load word: rs1=0x1000, imm=0x8, size=W, no forwarding -> next cycle mem_valid=1, addr=0x1008, be=0xF, mem_last=1, mem_we=0.
2. Forward priority: fwd_vld=3'b011, fwd_rd={x,5,5}, data0=0x200, data1=0x300, rs1_idx=5, imm=4, store byte -> addr=0x204, be=0x1, mem_we=1. Repeat with rs1_idx=0 -> rs1_data is used.
3. lhu at off=2 -> be=0xC, mem_sign=0. lh at off=2 -> mem_sign=1.
4. Misaligned word at 0x1003:
   - Split build: beat0 addr=0x1000, be=0x8, mem_last=0; beat1 addr=0x1004, be=0x7, mem_last=1.
   - Non-split build: misalign_err=1 for one cycle, mem_valid=0.
5. Stall and throughput: hold mem_ready=0 for 3 cycles -> outputs stable and req_ready=0. Release with a second request pending -> next beat issues the following cycle.
6. Reset mid-access: assert addr_rst low during BEAT0 -> all outputs 0 immediately, req_ready=1 after release, and no BEAT1 occurs.
